// File: rtl/ex_hazard_ctrl_if.sv
// EX-stage hazard/forwarding control bundle: instruction and control inputs, mux selects, stall/flush, counters.
// Latency: pure wiring, no storage.
// Backpressure: none; stall_De/flush_* are the only flow-control signals and they are combinational.
interface ex_hazard_ctrl_if #(
  parameter int XLEN = 32
);
  logic [31:0]     inst_De;
  logic [31:0]     inst_Ex;
  logic            a_use_pc;
  logic            b_use_imm;
  logic            br_taken;
  logic [1:0]      busA_mux_sel;
  logic [1:0]      busB_mux_sel;
  logic            stall_De;
  logic            flush_De;
  logic            flush_Ex;
  logic [XLEN-1:0] stall_cnt;
  logic [XLEN-1:0] flush_cnt;

  // Pipeline side: drives instructions and EX control, consumes selects and stall/flush.
  modport master (
    output inst_De, inst_Ex, a_use_pc, b_use_imm, br_taken,
    input  busA_mux_sel, busB_mux_sel, stall_De, flush_De, flush_Ex, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  inst_De, inst_Ex, a_use_pc, b_use_imm, br_taken,
    output busA_mux_sel, busB_mux_sel, stall_De, flush_De, flush_Ex, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard and forwarding controller: operand forwarding, load-use stall, branch flush, event counters.
// Latency: selects/stall/flush are combinational (0 cycles); shadow pipe and counters update on posedge clk.
// Backpressure: load-use raises stall_De + flush_Ex for one cycle; a taken branch flushes DE and EX and overrides the stall.
module ex_hazard_ctrl #(
  parameter int          XLEN     = 32,
  parameter int          RA_W     = 5,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic            wr;
    logic            ld;
  } shadow_t;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            wr;
    logic            ld;
    logic            uses_rs1;
    logic            uses_rs2;
  } dec_t;

  // Minimal decode: only the fields hazard detection needs. rd==x0 never counts as a write,
  // which is what keeps x0 out of every forwarding and load-use comparison.
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t       d;
    logic [6:0] op;
    op         = inst[6:0];
    d.rd       = inst[7 +: RA_W];
    d.rs1      = inst[15 +: RA_W];
    d.rs2      = inst[20 +: RA_W];
    d.wr       = (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                             7'b0010111, 7'b1101111, 7'b1100111})
                 && (d.rd != '0) && (inst != NOP_INST);
    d.ld       = (op == 7'b0000011);
    d.uses_rs1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    d.uses_rs2 = (op inside {7'b0110011, 7'b0100011, 7'b1100011});
    return d;
  endfunction

  dec_t            dec_de;
  dec_t            dec_ex;
  shadow_t         ma_q;
  shadow_t         wb_q;
  logic            load_use;
  logic            stall;
  logic [XLEN-1:0] stall_cnt_q;
  logic [XLEN-1:0] flush_cnt_q;

  assign dec_de = decode(bus.inst_De);
  assign dec_ex = decode(bus.inst_Ex);

  // Shadow pipe always advances; a stall holds only PC/DE, EX receives a bubble instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_q <= '0;
      wb_q <= '0;
    end else begin
      ma_q <= '{rd: dec_ex.rd, wr: dec_ex.wr, ld: dec_ex.ld};
      wb_q <= ma_q;
    end
  end

  // Operand A select: PC beats forwarding; MA beats WB; a load in MA has no data yet.
  always_comb begin
    bus.busA_mux_sel = 2'b00;
    if (bus.a_use_pc)
      bus.busA_mux_sel = 2'b01;
    else if (ma_q.wr && !ma_q.ld && (ma_q.rd == dec_ex.rs1))
      bus.busA_mux_sel = 2'b10;
    else if (wb_q.wr && (wb_q.rd == dec_ex.rs1))
      bus.busA_mux_sel = 2'b11;
  end

  // Operand B select: immediate beats forwarding; same MA/WB priority as operand A.
  always_comb begin
    bus.busB_mux_sel = 2'b00;
    if (bus.b_use_imm)
      bus.busB_mux_sel = 2'b01;
    else if (ma_q.wr && !ma_q.ld && (ma_q.rd == dec_ex.rs2))
      bus.busB_mux_sel = 2'b10;
    else if (wb_q.wr && (wb_q.rd == dec_ex.rs2))
      bus.busB_mux_sel = 2'b11;
  end

  // Load-use hazard and stall/flush generation; a taken branch discards the stall.
  always_comb begin
    load_use     = dec_ex.ld && dec_ex.wr &&
                   ((dec_de.uses_rs1 && (dec_de.rs1 == dec_ex.rd)) ||
                    (dec_de.uses_rs2 && (dec_de.rs2 == dec_ex.rd)));
    stall        = load_use && !bus.br_taken;
    bus.stall_De = stall;
    bus.flush_De = bus.br_taken;
    bus.flush_Ex = bus.br_taken || load_use;
  end

  // Saturating event counters: hold at all-ones rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + XLEN'(1);
      if (bus.br_taken && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + XLEN'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl; a narrow-counter second instance exercises saturation.
module tb_ex_hazard_ctrl;

  localparam logic [31:0] ADDI_X5   = 32'h0070_0293; // addi x5,x0,7
  localparam logic [31:0] ADD_655   = 32'h0052_8333; // add x6,x5,x5
  localparam logic [31:0] ADD_651   = 32'h0012_8333; // add x6,x5,x1
  localparam logic [31:0] ADD_652   = 32'h0022_8333; // add x6,x5,x2
  localparam logic [31:0] LW_X5     = 32'h0000_A283; // lw x5,0(x1)
  localparam logic [31:0] BEQ_12    = 32'h0020_8063; // beq x1,x2,0
  localparam logic [31:0] ADD_X0    = 32'h0020_8033; // add x0,x1,x2
  localparam logic [31:0] SUB_300   = 32'h4000_01B3; // sub x3,x0,x0
  localparam logic [31:0] AUIPC_X5  = 32'h0002_8297; // auipc x5,0x28 (rs1 field = 5)
  localparam logic [31:0] NOP       = 32'h0000_0013;

  localparam int S_A = 0, S_B = 1, S_ST = 2, S_FD = 3, S_FE = 4,
                 S_SC = 5, S_FC = 6, S_SSC = 7, S_SFC = 8;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  logic clk;
  logic rst_n;

  ex_hazard_ctrl_if #(.XLEN(32)) bus ();
  ex_hazard_ctrl_if #(.XLEN(4))  sbus ();

  ex_hazard_ctrl #(.XLEN(32)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  ex_hazard_ctrl #(.XLEN(4))  u_small (.clk(clk), .rst_n(rst_n), .bus(sbus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sb_t         sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_scnt = '0;
  logic [31:0] m_fcnt = '0;
  logic [3:0]  m_sscnt = '0;
  logic [3:0]  m_sfcnt = '0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_A:     return {30'b0, bus.busA_mux_sel};
      S_B:     return {30'b0, bus.busB_mux_sel};
      S_ST:    return {31'b0, bus.stall_De};
      S_FD:    return {31'b0, bus.flush_De};
      S_FE:    return {31'b0, bus.flush_Ex};
      S_SC:    return bus.stall_cnt;
      S_FC:    return bus.flush_cnt;
      S_SSC:   return {28'b0, sbus.stall_cnt};
      S_SFC:   return {28'b0, sbus.flush_cnt};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] e);
    sb_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = e;
    sb_q.push_back(it);
  endtask

  task automatic push_cnts(input string tag);
    push({tag, ".scnt"},  S_SC,  m_scnt);
    push({tag, ".fcnt"},  S_FC,  m_fcnt);
    push({tag, ".sscnt"}, S_SSC, {28'b0, m_sscnt});
    push({tag, ".sfcnt"}, S_SFC, {28'b0, m_sfcnt});
  endtask

  task automatic drain();
    sb_t         it;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      it  = sb_q.pop_front();
      got = obs(it.sel);
      n_chk++;
      assert (got === it.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", it.tag, got, it.exp);
      end
    end
  endtask

  task automatic drive(input logic [31:0] de, input logic [31:0] ex,
                       input logic apc, input logic bimm, input logic br);
    bus.inst_De    = de;  sbus.inst_De   = de;
    bus.inst_Ex    = ex;  sbus.inst_Ex   = ex;
    bus.a_use_pc   = apc; sbus.a_use_pc  = apc;
    bus.b_use_imm  = bimm; sbus.b_use_imm = bimm;
    bus.br_taken   = br;  sbus.br_taken  = br;
  endtask

  // One pipeline cycle: drive at negedge, check settled outputs, then advance the counter model.
  task automatic step(input string tag, input logic [31:0] de, input logic [31:0] ex,
                      input logic apc, input logic bimm, input logic br,
                      input logic [1:0] ea, input logic [1:0] eb,
                      input logic es, input logic efd, input logic efe);
    @(negedge clk);
    drive(de, ex, apc, bimm, br);
    #2;
    push({tag, ".busA"}, S_A, {30'b0, ea});
    push({tag, ".busB"}, S_B, {30'b0, eb});
    push({tag, ".stall"}, S_ST, {31'b0, es});
    push({tag, ".flushDe"}, S_FD, {31'b0, efd});
    push({tag, ".flushEx"}, S_FE, {31'b0, efe});
    push_cnts(tag);
    drain();
    if (es && m_scnt != '1)  m_scnt  = m_scnt + 1;
    if (es && m_sscnt != '1) m_sscnt = m_sscnt + 1;
    if (br && m_fcnt != '1)  m_fcnt  = m_fcnt + 1;
    if (br && m_sfcnt != '1) m_sfcnt = m_sfcnt + 1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    push("rst.busA", S_A, 32'd0);
    push("rst.busB", S_B, 32'd0);
    push("rst.stall", S_ST, 32'd0);
    push("rst.flushEx", S_FE, 32'd0);
    push_cnts("rst");
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back dependency forwards from MA; one-apart forwards from WB.
    step("t1_addi",  '0, ADDI_X5, 0, 1, 0, 2'b00, 2'b01, 0, 0, 0);
    step("t1_fwdma", '0, ADD_655, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0);
    step("t2_addi",  '0, ADDI_X5, 0, 1, 0, 2'b00, 2'b01, 0, 0, 0);
    step("t2_nop",   '0, NOP,     0, 1, 0, 2'b00, 2'b01, 0, 0, 0);
    step("t2_fwdwb", '0, ADD_651, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0);

    // Load-use: one stall cycle, bubble, then WB forward of the load result.
    step("t3_lu",     ADD_652, LW_X5,   0, 1, 0, 2'b00, 2'b01, 1, 0, 1);
    step("t3_bubble", ADD_652, NOP,     0, 1, 0, 2'b00, 2'b01, 0, 0, 0);
    step("t3_fwdwb",  NOP,     ADD_652, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0);

    // A load sitting in MA must not be forwarded from MA.
    step("ld_ex",    NOP, LW_X5,   0, 1, 0, 2'b00, 2'b01, 0, 0, 0);
    step("ld_in_ma", NOP, ADD_652, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // Taken branch flushes; when it coincides with load-use the flush wins.
    step("t4_beq",   LW_X5,   BEQ_12, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1);
    step("t4_br_lu", ADD_652, LW_X5,  0, 1, 1, 2'b00, 2'b01, 0, 1, 1);

    // x0 never forwarded; PC/imm selects override matching forwards; MA beats WB.
    step("t5_addx0",   NOP, ADD_X0,   0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    step("t5_subx0",   NOP, SUB_300,  0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    step("t5_addi",    NOP, ADDI_X5,  0, 1, 0, 2'b00, 2'b01, 0, 0, 0);
    step("t5_auipcpc", NOP, AUIPC_X5, 1, 1, 0, 2'b01, 2'b01, 0, 0, 0);
    step("t5_maprio",  NOP, AUIPC_X5, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0);

    // Flush counter saturation on the narrow instance.
    for (int i = 0; i < 15; i++)
      step($sformatf("fsat%0d", i), NOP, NOP, 0, 1, 1, 2'b00, 2'b01, 0, 1, 1);

    // Stall counter saturation: narrow counter reaches 4'hE then takes three more stalls.
    for (int i = 0; i < 16; i++)
      step($sformatf("ssat%0d", i), ADD_652, LW_X5, 0, 1, 0, 2'b00, 2'b01, 1, 0, 1);

    // Reset asserted mid-stall: counters clear at once, stall still follows inputs.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    push("mrst.stall", S_ST, 32'd1);
    push("mrst.flushEx", S_FE, 32'd1);
    m_scnt = '0; m_fcnt = '0; m_sscnt = '0; m_sfcnt = '0;
    push_cnts("mrst");
    drain();
    // Shadow held WB = lw x5; cleared shadow means no forward for x5.
    drive(NOP, ADD_655, 1'b0, 1'b0, 1'b0);
    #1;
    push("mrst.busA", S_A, 32'd0);
    push("mrst.busB", S_B, 32'd0);
    push("mrst.nostall", S_ST, 32'd0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    push("post_rst.busA", S_A, 32'd0);
    push("post_rst.busB", S_B, 32'd0);
    push_cnts("post_rst");
    drain();
    step("post_rst2", NOP, ADD_655, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
